depp_host: RTL and testbench

DEPP_HOST -- requirements
Module: depp_host

---
 rtl/depp_host.sv | 187 ++++++++++++++++++
 tb/tb_depp_host.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depp_host.sv
// depp_host: DEPP bus master that runs one address/data transaction per
// accepted command.
//
// Ports
//   clkFast, rst            sole clock; asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_write               1 = write, 0 = read
//   cmd_adr, cmd_wdata      register address and write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               read data (unchanged by writes)
//   rsp_timeout             qualifies rsp_valid when the peripheral stalled
//   depp_db                 bidirectional data bus
//   depp_astb, depp_dstb    address/data strobes (active-low)
//   depp_write              low = write direction
//   depp_wait               peripheral acknowledge (asynchronous)
module depp_host #(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clkFast,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_adr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    inout  wire  [7:0] depp_db,
    output logic       depp_astb,
    output logic       depp_dstb,
    output logic       depp_write,
    input  logic       depp_wait
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STB, A_REL, D_SETUP, D_STB, D_REL, DONE
    } state_t;

    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_n;
    logic        wait_s1, wait_s2;
    logic        wr_q, to_q;
    logic [7:0]  adr_q, wdata_q;
    logic        cache_valid;
    logic [7:0]  cached_adr;
    logic [3:0]  scnt;
    logic [15:0] wcnt;
    logic        cache_set, cache_clr, to_set, rd_cap;
    logic        setup_done, to_hit;
    logic        db_oe;
    logic [7:0]  db_out;

    assign depp_db    = db_oe ? db_out : 8'bz;
    assign setup_done = (scnt == SETUP_LAST);
    // The cycle with wcnt == TO_LAST is the TIMEOUT_CYC-th cycle spent waiting.
    assign to_hit     = (wcnt == TO_LAST);

    always_ff @(posedge clkFast or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_s1     <= 1'b0;
            wait_s2     <= 1'b0;
            wr_q        <= 1'b0;
            to_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            cache_valid <= 1'b0;
            cached_adr  <= '0;
            scnt        <= '0;
            wcnt        <= '0;
            rsp_rdata   <= '0;
        end else begin
            wait_s1 <= depp_wait;
            wait_s2 <= wait_s1;
            state_q <= state_n;
            if (state_q == IDLE && cmd_valid) begin
                wr_q    <= cmd_write;
                adr_q   <= cmd_adr;
                wdata_q <= cmd_wdata;
                to_q    <= 1'b0;
            end
            if (to_set)
                to_q <= 1'b1;
            // Both counters restart on every state change.
            scnt <= (state_n != state_q) ? 4'd0 : scnt + 4'd1;
            wcnt <= (state_n != state_q) ? 16'd0 : wcnt + 16'd1;
            if (cache_set) begin
                cached_adr  <= adr_q;
                cache_valid <= 1'b1;
            end
            if (cache_clr)
                cache_valid <= 1'b0;
            if (rd_cap)
                rsp_rdata <= depp_db;
        end
    end

    always_comb begin
        state_n     = state_q;
        cache_set   = 1'b0;
        cache_clr   = 1'b0;
        to_set      = 1'b0;
        rd_cap      = 1'b0;
        depp_astb   = 1'b1;
        depp_dstb   = 1'b1;
        depp_write  = 1'b1;
        db_oe       = 1'b0;
        db_out      = adr_q;
        cmd_ready   = (state_q == IDLE);
        rsp_valid   = (state_q == DONE);
        rsp_timeout = (state_q == DONE) && to_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid)
                    state_n = (cache_valid && cmd_adr == cached_adr)
                            ? D_SETUP : A_SETUP;
            end
            A_SETUP: begin
                depp_write = 1'b0;
                db_oe      = 1'b1;
                if (setup_done)
                    state_n = A_STB;
            end
            A_STB: begin
                depp_astb  = 1'b0;
                depp_write = 1'b0;
                db_oe      = 1'b1;
                if (wait_s2)
                    state_n = A_REL;
                else if (to_hit)
                    state_n = DONE;
            end
            A_REL: begin
                depp_write = 1'b0;
                db_oe      = 1'b1;
                if (!wait_s2) begin
                    state_n   = D_SETUP;
                    cache_set = 1'b1;
                end else if (to_hit) begin
                    state_n = DONE;
                end
            end
            D_SETUP: begin
                depp_write = !wr_q;
                db_oe      = wr_q;
                db_out     = wdata_q;
                if (setup_done)
                    state_n = D_STB;
            end
            D_STB: begin
                depp_dstb  = 1'b0;
                depp_write = !wr_q;
                db_oe      = wr_q;
                db_out     = wdata_q;
                if (wait_s2) begin
                    state_n = D_REL;
                    rd_cap  = !wr_q;
                end else if (to_hit) begin
                    state_n = DONE;
                end
            end
            D_REL: begin
                depp_write = !wr_q;
                db_oe      = wr_q;
                db_out     = wdata_q;
                if (!wait_s2)
                    state_n = DONE;
                else if (to_hit)
                    state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A stalled peripheral aborts the transaction and forgets the address.
        if (state_q inside {A_STB, A_REL, D_STB, D_REL}
            && state_n == DONE && to_hit
            && !(state_q == D_REL && !wait_s2)) begin
            to_set    = 1'b1;
            cache_clr = 1'b1;
        end
    end

endmodule

// File: tb/tb_depp_host.sv
// tb_depp_host: scoreboard bench for depp_host with a DEPP peripheral model
// and a bus protocol monitor.
module tb_depp_host;

    localparam int SETUP = 2;
    localparam int TMO   = 8;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       addr;
        logic       to;
        int         alow;
        logic       aa;
        logic       ad;
    } row_t;

    typedef struct {
        logic       addr;
        logic       to;
        logic [7:0] rd;
        int         alow;
    } exp_t;

    logic       clkFast = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_adr, cmd_wdata, rsp_rdata;
    logic       rsp_valid, rsp_timeout;
    logic       depp_astb, depp_dstb, depp_write, depp_wait;
    tri1  [7:0] depp_db;

    logic       ack_a, ack_d;
    logic [7:0] rd_val;
    int         checks = 0;
    int         failures = 0;
    logic       astb_seen, dstb_w, rsp_seen, obs_to;
    logic [7:0] astb_db, dstb_db, obs_rdata;
    int         astb_low;
    int         rsp_cnt = 0;
    logic [7:0] last_rd;
    exp_t       sb[$];

    logic       pa, pd;
    logic [8:0] key, pkey;
    int         stable;

    always #5 clkFast = ~clkFast;

    depp_host #(.SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO)) dut (
        .clkFast    (clkFast),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_adr    (cmd_adr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .depp_db    (depp_db),
        .depp_astb  (depp_astb),
        .depp_dstb  (depp_dstb),
        .depp_write (depp_write),
        .depp_wait  (depp_wait)
    );

    // Peripheral returns read data while a read data strobe is low.
    assign depp_db = (!depp_dstb && depp_write) ? rd_val : 8'bz;

    // Peripheral acknowledge: raise wait a few cycles into an enabled
    // strobe, drop it once both strobes are high.
    initial begin : periph
        int n;
        n = 0;
        depp_wait = 1'b0;
        forever begin
            @(posedge clkFast);
            #1;
            if (!rst) begin
                n = 0;
                depp_wait = 1'b0;
            end else if ((!depp_astb && ack_a) || (!depp_dstb && ack_d)) begin
                n++;
                if (n >= 3)
                    depp_wait = 1'b1;
            end else if (depp_astb && depp_dstb) begin
                n = 0;
                depp_wait = 1'b0;
            end
        end
    end

    // Protocol monitor and response capture.
    initial begin : mon
        pa = 1'b1;
        pd = 1'b1;
        pkey = 9'h100;
        stable = 0;
        forever begin
            @(negedge clkFast);
            if (!rst) begin
                pa = 1'b1;
                pd = 1'b1;
                pkey = 9'h100;
                stable = 0;
            end else begin
                key = {depp_write, depp_write ? 8'h00 : depp_db};
                if (key === pkey)
                    stable++;
                else
                    stable = 0;
                pkey = key;
                checks++;
                if (!depp_astb && !depp_dstb) begin
                    failures++;
                    $display("FAIL strobe_overlap astb=%b dstb=%b want not both 0",
                             depp_astb, depp_dstb);
                end
                if (!depp_dstb && depp_write) begin
                    checks++;
                    if (depp_db !== rd_val) begin
                        failures++;
                        $display("FAIL read_bus_drive db=%h want %h", depp_db, rd_val);
                    end
                end
                if (depp_write && depp_dstb && depp_astb) begin
                    checks++;
                    if (depp_db !== 8'hFF) begin
                        failures++;
                        $display("FAIL db_released db=%h want ff", depp_db);
                    end
                end
                if ((!depp_astb && pa) || (!depp_dstb && pd)) begin
                    checks++;
                    if (stable < SETUP) begin
                        failures++;
                        $display("FAIL setup_hold stable=%0d want >=%0d", stable, SETUP);
                    end
                end
                if (!depp_astb && pa) begin
                    astb_seen = 1'b1;
                    astb_db = depp_db;
                end
                if (!depp_astb)
                    astb_low++;
                if (!depp_dstb && pd) begin
                    dstb_db = depp_db;
                    dstb_w = depp_write;
                end
                if (rsp_valid) begin
                    rsp_seen = 1'b1;
                    rsp_cnt++;
                    obs_to = rsp_timeout;
                    obs_rdata = rsp_rdata;
                end
                pa = depp_astb;
                pd = depp_dstb;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic send_cmd(input row_t r);
        exp_t e;
        @(negedge clkFast);
        ack_a = r.aa;
        ack_d = r.ad;
        if (!r.w)
            rd_val = r.d;
        e.addr = r.addr;
        e.to = r.to;
        e.alow = r.alow;
        e.rd = (!r.w && !r.to) ? r.d : last_rd;
        last_rd = e.rd;
        sb.push_back(e);
        astb_seen = 1'b0;
        astb_low = 0;
        astb_db = 8'h00;
        dstb_db = 8'h00;
        dstb_w = 1'b0;
        rsp_seen = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = r.w;
        cmd_adr = r.a;
        cmd_wdata = r.w ? r.d : ~r.d;
        @(posedge clkFast);
        #1;
        cmd_valid = 1'b0;
        cmd_write = ~r.w;
        cmd_adr = ~r.a;
        cmd_wdata = 8'h5C ^ r.d;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clkFast);
            if (rsp_seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #3;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL rst_ready got=%b want 1", cmd_ready);
        end
        checks++;
        if ({depp_astb, depp_dstb, depp_write} !== 3'b111) begin
            failures++;
            $display("FAIL rst_strobes got=%b%b%b want 111", depp_astb, depp_dstb, depp_write);
        end
        checks++;
        if (depp_db !== 8'hFF) begin
            failures++; $display("FAIL rst_db got=%h want ff", depp_db);
        end
        checks++;
        if ({rsp_valid, rsp_timeout} !== 2'b00) begin
            failures++; $display("FAIL rst_rsp got=%b%b want 00", rsp_valid, rsp_timeout);
        end
        checks++;
        if (rsp_rdata !== 8'h00) begin
            failures++; $display("FAIL rst_rdata got=%h want 00", rsp_rdata);
        end
        repeat (3) @(posedge clkFast);
        @(negedge clkFast);
        rst = 1'b1;
        @(negedge clkFast);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL post_rst_ready got=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        row_t rows[2];
        exp_t e;
        bit   ok;
        rows[0] = '{1'b1, 8'h05, 8'hA5, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        rows[1] = '{1'b0, 8'h85, 8'h5A, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        foreach (rows[i]) begin
            send_cmd(rows[i]);
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++; $display("FAIL busy_ready got=%b want 0", cmd_ready);
            end
            wait_rsp(ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                failures++; $display("FAIL wr_rd_rsp got=none want rsp_valid");
                continue;
            end
            checks++;
            if (obs_to !== e.to) begin
                failures++; $display("FAIL wr_rd_timeout got=%b want %b", obs_to, e.to);
            end
            checks++;
            if (obs_rdata !== e.rd) begin
                failures++; $display("FAIL wr_rd_rdata got=%h want %h", obs_rdata, e.rd);
            end
            checks++;
            if (astb_seen !== e.addr) begin
                failures++; $display("FAIL wr_rd_addr got=%b want %b", astb_seen, e.addr);
            end
            checks++;
            if (astb_db !== rows[i].a) begin
                failures++; $display("FAIL wr_rd_adr_bus got=%h want %h", astb_db, rows[i].a);
            end
            checks++;
            if (dstb_w !== ~rows[i].w) begin
                failures++; $display("FAIL wr_rd_dir got=%b want %b", dstb_w, ~rows[i].w);
            end
            if (rows[i].w) begin
                checks++;
                if (dstb_db !== rows[i].d) begin
                    failures++; $display("FAIL wr_data_bus got=%h want %h", dstb_db, rows[i].d);
                end
            end
        end
    endtask

    task automatic test_cache();
        row_t rows[4];
        exp_t e;
        bit   ok;
        rows[0] = '{1'b1, 8'h05, 8'h11, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        rows[1] = '{1'b0, 8'h05, 8'h3C, 1'b0, 1'b0, -1, 1'b1, 1'b1};
        rows[2] = '{1'b0, 8'h06, 8'hC3, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        rows[3] = '{1'b0, 8'h06, 8'h99, 1'b0, 1'b0, -1, 1'b1, 1'b1};
        foreach (rows[i]) begin
            send_cmd(rows[i]);
            wait_rsp(ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                failures++; $display("FAIL cache_rsp[%0d] got=none want rsp_valid", i);
                continue;
            end
            checks++;
            if (obs_to !== e.to) begin
                failures++; $display("FAIL cache_timeout[%0d] got=%b want %b", i, obs_to, e.to);
            end
            checks++;
            if (obs_rdata !== e.rd) begin
                failures++; $display("FAIL cache_rdata[%0d] got=%h want %h", i, obs_rdata, e.rd);
            end
            checks++;
            if (astb_seen !== e.addr) begin
                failures++; $display("FAIL cache_addr[%0d] got=%b want %b", i, astb_seen, e.addr);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[4];
        exp_t e;
        bit   ok;
        rows[0] = '{1'b0, 8'h40, 8'hAB, 1'b1, 1'b1, TMO, 1'b0, 1'b1};
        rows[1] = '{1'b0, 8'h40, 8'h12, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        rows[2] = '{1'b0, 8'h40, 8'h34, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        rows[3] = '{1'b0, 8'h40, 8'h56, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        foreach (rows[i]) begin
            send_cmd(rows[i]);
            wait_rsp(ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                failures++; $display("FAIL to_rsp[%0d] got=none want rsp_valid", i);
                continue;
            end
            checks++;
            if (obs_to !== e.to) begin
                failures++; $display("FAIL to_flag[%0d] got=%b want %b", i, obs_to, e.to);
            end
            checks++;
            if (obs_rdata !== e.rd) begin
                failures++; $display("FAIL to_rdata[%0d] got=%h want %h", i, obs_rdata, e.rd);
            end
            checks++;
            if (astb_seen !== e.addr) begin
                failures++; $display("FAIL to_addr[%0d] got=%b want %b", i, astb_seen, e.addr);
            end
            if (e.alow >= 0) begin
                checks++;
                if (astb_low != e.alow) begin
                    failures++; $display("FAIL to_astb_low[%0d] got=%0d want %0d", i, astb_low, e.alow);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t r;
        exp_t e;
        bit   found, ok;
        int   base;
        r = '{1'b1, 8'h77, 8'hEE, 1'b1, 1'b0, -1, 1'b1, 1'b1};
        base = rsp_cnt;
        send_cmd(r);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkFast);
            if (!depp_dstb) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL mid_dstb got=high want dstb low");
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({depp_astb, depp_dstb, depp_write} !== 3'b111) begin
            failures++;
            $display("FAIL mid_strobes got=%b%b%b want 111", depp_astb, depp_dstb, depp_write);
        end
        checks++;
        if (depp_db !== 8'hFF) begin
            failures++; $display("FAIL mid_db got=%h want ff", depp_db);
        end
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            failures++; $display("FAIL mid_hs got=%b%b want 10", cmd_ready, rsp_valid);
        end
        repeat (3) @(posedge clkFast);
        @(negedge clkFast);
        rst = 1'b1;
        sb.delete();
        last_rd = 8'h00;
        repeat (10) @(posedge clkFast);
        #1;
        checks++;
        if (rsp_cnt != base) begin
            failures++; $display("FAIL mid_no_rsp got=%0d want %0d", rsp_cnt, base);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL mid_ready got=%b want 1", cmd_ready);
        end
        checks++;
        if (rsp_rdata !== 8'h00) begin
            failures++; $display("FAIL mid_rdata got=%h want 00", rsp_rdata);
        end
        send_cmd(r);
        wait_rsp(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            failures++; $display("FAIL mid_retry_rsp got=none want rsp_valid");
        end else begin
            checks++;
            if (astb_seen !== e.addr) begin
                failures++; $display("FAIL mid_retry_addr got=%b want %b", astb_seen, e.addr);
            end
        end
    endtask

    initial begin : main
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_adr = 8'h00;
        cmd_wdata = 8'h00;
        ack_a = 1'b1;
        ack_d = 1'b1;
        rd_val = 8'h00;
        last_rd = 8'h00;
        rsp_seen = 1'b0;
        astb_low = 0;
        test_reset();
        test_write_read();
        test_cache();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
